// File: rtl/fp_latency_checker.sv
// Latency-aligned checker for pipelined FP benches: delays expected words by
// LATENCY cycles, compares against the DUT with a ULP tolerance, keeps stats.
module fp_latency_checker #(
    parameter int unsigned WIDTH      = 32,
    parameter int unsigned LATENCY    = 4,
    parameter int unsigned TOL        = 0,
    parameter int unsigned CNT_W      = 16,
    parameter int unsigned NUM_CHECKS = 0
) (
    input  logic             CLK,
    input  logic             RST_n,
    input  logic             EN,
    input  logic [WIDTH-1:0] EXP_IN,
    input  logic [WIDTH-1:0] DOUT_IN,
    input  logic             CLR,
    output logic             CMP_VALID,
    output logic             CMP_ERR,
    output logic [CNT_W-1:0] CHECK_CNT,
    output logic [CNT_W-1:0] ERR_CNT,
    output logic             ERR_FLAG,
    output logic [CNT_W-1:0] FIRST_ERR_IDX,
    output logic [WIDTH-1:0] FIRST_ERR_EXP,
    output logic [WIDTH-1:0] FIRST_ERR_GOT,
    output logic             DONE
);
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    logic             r_vld [LATENCY];
    logic [WIDTH-1:0] r_dat [LATENCY];

    state_t           r_state;
    state_t           w_state_nxt;
    logic             r_cmp_valid;
    logic             r_cmp_err;
    logic             r_err_flag;
    logic [CNT_W-1:0] r_chk_cnt;
    logic [CNT_W-1:0] r_err_cnt;
    logic [CNT_W-1:0] r_first_idx;
    logic [WIDTH-1:0] r_first_exp;
    logic [WIDTH-1:0] r_first_got;

    logic             w_tail_vld;
    logic [WIDTH-1:0] w_exp;
    logic [WIDTH-2:0] w_mag_exp;
    logic [WIDTH-2:0] w_mag_got;
    logic [WIDTH-2:0] w_diff;
    logic             w_sign_diff;
    logic             w_both_zero;
    logic             w_fail;
    logic             w_do_cmp;
    logic [CNT_W-1:0] w_chk_inc;
    logic [CNT_W-1:0] w_err_inc;

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            for (int unsigned i = 0; i < LATENCY; i++) begin
                r_vld[i] <= 1'b0;
                r_dat[i] <= '0;
            end
        end else begin
            r_vld[0] <= EN;
            r_dat[0] <= EXP_IN;
            for (int unsigned i = 1; i < LATENCY; i++) begin
                r_vld[i] <= r_vld[i-1];
                r_dat[i] <= r_dat[i-1];
            end
        end
    end

    // Sign-magnitude compare: +0 and -0 are equal, otherwise opposite signs fail.
    assign w_tail_vld  = r_vld[LATENCY-1];
    assign w_exp       = r_dat[LATENCY-1];
    assign w_mag_exp   = w_exp[WIDTH-2:0];
    assign w_mag_got   = DOUT_IN[WIDTH-2:0];
    assign w_sign_diff = w_exp[WIDTH-1] ^ DOUT_IN[WIDTH-1];
    assign w_both_zero = (w_mag_exp == '0) && (w_mag_got == '0);
    assign w_diff      = (w_mag_exp >= w_mag_got) ? (w_mag_exp - w_mag_got)
                                                  : (w_mag_got - w_mag_exp);
    assign w_fail      = w_sign_diff ? !w_both_zero : (64'(w_diff) > 64'(TOL));

    assign w_chk_inc = (r_chk_cnt == '1) ? r_chk_cnt : r_chk_cnt + CNT_W'(1);
    assign w_err_inc = (r_err_cnt == '1) ? r_err_cnt : r_err_cnt + CNT_W'(1);

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_do_cmp    = 1'b0;
        case (r_state)
            S_IDLE, S_RUN: begin
                if (w_tail_vld) begin
                    w_do_cmp = 1'b1;
                    if ((NUM_CHECKS != 0) && (64'(w_chk_inc) == 64'(NUM_CHECKS)))
                        w_state_nxt = S_DONE;
                    else
                        w_state_nxt = S_RUN;
                end
            end
            S_DONE:  w_state_nxt = S_DONE;
            default: w_state_nxt = S_IDLE;
        endcase
        // A clear on the same edge as a comparison drops that result.
        if (CLR) begin
            w_state_nxt = S_IDLE;
            w_do_cmp    = 1'b0;
        end
    end

    always_ff @(posedge CLK or negedge RST_n) begin
        if (!RST_n) begin
            r_cmp_valid <= 1'b0;
            r_cmp_err   <= 1'b0;
            r_err_flag  <= 1'b0;
            r_chk_cnt   <= '0;
            r_err_cnt   <= '0;
            r_first_idx <= '0;
            r_first_exp <= '0;
            r_first_got <= '0;
        end else if (CLR) begin
            r_cmp_valid <= 1'b0;
            r_cmp_err   <= 1'b0;
            r_err_flag  <= 1'b0;
            r_chk_cnt   <= '0;
            r_err_cnt   <= '0;
            r_first_idx <= '0;
            r_first_exp <= '0;
            r_first_got <= '0;
        end else begin
            r_cmp_valid <= w_do_cmp;
            r_cmp_err   <= w_do_cmp && w_fail;
            if (w_do_cmp) begin
                r_chk_cnt <= w_chk_inc;
                if (w_fail) begin
                    r_err_cnt  <= w_err_inc;
                    r_err_flag <= 1'b1;
                    if (!r_err_flag) begin
                        r_first_idx <= r_chk_cnt;
                        r_first_exp <= w_exp;
                        r_first_got <= DOUT_IN;
                    end
                end
            end
        end
    end

    assign CMP_VALID     = r_cmp_valid;
    assign CMP_ERR       = r_cmp_err;
    assign CHECK_CNT     = r_chk_cnt;
    assign ERR_CNT       = r_err_cnt;
    assign ERR_FLAG      = r_err_flag;
    assign FIRST_ERR_IDX = r_first_idx;
    assign FIRST_ERR_EXP = r_first_exp;
    assign FIRST_ERR_GOT = r_first_got;
    assign DONE          = (r_state == S_DONE);

endmodule
